ex_result_stage: RTL and testbench
==================================

# ex_result_stage

Registered execute-result stage directly downstream of the operand adder. It takes the adder's sum, carry-out and signed-overflow flags plus the decoded operation, and produces the architectural result (ADD/SUB/SLT/SLTU) or the branch decision (BEQ..BGEU). Results go to writeback and fetch over a valid/ready handshake with one cycle of latency.

## Interface
- WIDTH, 32: datapath width; must equal the adder width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- valid_i  in  1  upstream holds a valid operation.
- ready_o  out  1  stage can accept; transfer occurs when valid_i & ready_o.
- op_i  in  4  operation code (ex_pkg::ex_op_e).
- sum_i  in  WIDTH  adder sum.
- cout_i  in  1  adder unsigned carry-out.
- ovf_i  in  1  adder signed overflow.
- rd_i  in  5  destination register index, passed through.
- valid_o  out  1  result_o / taken_o / rd_o / illegal_o are valid.
- ready_i  in  1  downstream accepts; transfer occurs when valid_o & ready_i.
- result_o  out  WIDTH  registered result.
- taken_o  out  1  registered branch-taken flag.
- rd_o  out  5  registered destination index.
- illegal_o  out  1  registered flag for an unknown op_i.

## Operation
- Upstream contract: for SUB, SLT, SLTU and every branch, the adder computes a + ~b + 1. For ADD it computes a + b + 0.
- Derived terms: eq = (sum_i == 0); lt_s = sum_i[WIDTH-1] ^ ovf_i; lt_u = ~cout_i.
- ADD=0, SUB=1: result = sum_i; taken = 0.
- SLT=2: result = zero-extended lt_s; taken = 0.
- SLTU=3: result = zero-extended lt_u; taken = 0.
- Branch ops (result = 0 for all):
  - BEQ=4: taken = eq.
  - BNE=5: taken = ~eq.
  - BLT=6: taken = lt_s.
  - BGE=7: taken = ~lt_s.
  - BLTU=8: taken = lt_u.
  - BGEU=9: taken = ~lt_u.
- op 10..15: result = 0, taken = 0, illegal = 1; the stage still transfers the op normally.
- rd passes through unchanged for every op, including branches. Writeback must ignore rd on branches.
- Output fields change only when a new entry becomes the head. They are held stable while valid_o & ~ready_i (no combinational path from sum_i to any output).

## Timing
- Reset: valid_o = 0; result_o, rd_o, taken_o, illegal_o = 0; buffer empty.
- ready_o = 0 while rst_ni is low. ready_o = 1 from the first clock edge after deassertion.
- Latency: accepted at edge N -> valid_o high after edge N, i.e. visible in cycle N+1.
- Throughput: one op per cycle when ready_i stays high.
- Simultaneous accept and drain on the same edge:
  - The head is replaced by the new op.
  - valid_o stays 1 and no bubble is inserted.
- Reset asserted mid-operation: all buffered entries are discarded immediately (asynchronously); no partial output.
- Buffer states (only with EX_SKID_EN; otherwise a single register):
  - EMPTY: ready_o = 1; an accepted op goes to ONE.
  - ONE: ready_o = 1.
    - Accept with no drain -> TWO.
    - Drain with no accept -> EMPTY.
    - Accept and drain together -> ONE.
  - TWO: ready_o = 0.
    - A drain promotes the skid entry to head -> ONE.
    - valid_i is ignored.

## Configuration
- EX_SKID_EN defined:
  - Two-entry skid buffer using the states above.
  - ready_o is a register output with no combinational dependence on ready_i.
  - Full throughput is kept under backpressure.
- EX_SKID_EN undefined:
  - Single output register.
  - ready_o = ~valid_o | ready_i (combinational from ready_i).
  - Latency 1; same functional results.

## Structure
- Package ex_pkg holds:
  - ex_op_e (4-bit enum, encodings above);
  - ex_buf_state_e (EMPTY/ONE/TWO);
  - a packed struct ex_res_t {result, taken, rd, illegal}.
- Sub-module ex_res_compute: purely combinational decode from (op, sum, cout, ovf) to ex_res_t.
- The top level contains only the handshake and buffer logic.

## Test plan
- ADD 5+7: sum_i=12, op=ADD, ready_i=1 -> next cycle result_o=12, taken_o=0, valid_o=1.
- SLT -1 vs 1: sum_i=0xFFFFFFFE, ovf=0 -> result_o=1.
- SLTU 0xFFFFFFFF vs 1: sum_i=0xFFFFFFFE, cout=1 -> result_o=0.
- BEQ 9 vs 9: sum_i=0 -> taken_o=1.
- BLT 0x7FFFFFFF vs 0xFFFFFFFF: sum_i=0x80000000, ovf=1 -> lt_s=0, taken_o=0.
- Backpressure with EX_SKID_EN: ready_i held 0 while ops A, B, C are offered.
  - A and B are accepted; ready_o=0 during C.
  - Then ready_i=1: outputs A, B, C in order on consecutive cycles; no loss, no duplication.
- Reset mid-stream: assert rst_ni low while in TWO.
  - valid_o=0 immediately.
  - After release: ready_o=1 and no stale entry appears.
- Illegal op 12: illegal_o=1, result_o=0, transfer completes normally.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the execute-result stage.
//   EX_WIDTH        datapath width; equals the operand adder width
//   ex_op_e         4-bit operation code presented on op_i
//   ex_buf_state_e  occupancy of the output skid buffer (EX_SKID_EN builds)
//   ex_res_t        one buffered result entry {result, taken, rd, illegal}
package ex_pkg;

    localparam int unsigned EX_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLT  = 4'd2,
        OP_SLTU = 4'd3,
        OP_BEQ  = 4'd4,
        OP_BNE  = 4'd5,
        OP_BLT  = 4'd6,
        OP_BGE  = 4'd7,
        OP_BLTU = 4'd8,
        OP_BGEU = 4'd9
    } ex_op_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } ex_buf_state_e;

    typedef struct packed {
        logic [EX_WIDTH-1:0] result;
        logic                taken;
        logic [4:0]          rd;
        logic                illegal;
    } ex_res_t;

endpackage

// File: rtl/ex_res_compute.sv
// ex_res_compute: combinational decode of the adder outputs into a result entry.
//   op_i    operation code (ex_op_e encoding)
//   sum_i   adder sum
//   cout_i  adder unsigned carry-out
//   ovf_i   adder signed overflow
//   res_o   result/taken/illegal; rd is left zero and filled in by the caller
// For every compare and branch the adder has already formed a - b, so the
// relations fall out of the flags without a second comparator.
module ex_res_compute
    import ex_pkg::*;
(
    input  logic [3:0]          op_i,
    input  logic [EX_WIDTH-1:0] sum_i,
    input  logic                cout_i,
    input  logic                ovf_i,
    output ex_res_t             res_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (sum_i == '0);
    assign lt_s = sum_i[EX_WIDTH-1] ^ ovf_i;
    // a - b borrows exactly when no carry comes out of a + ~b + 1
    assign lt_u = ~cout_i;

    always_comb begin
        res_o = '0;
        case (op_i)
            OP_ADD,
            OP_SUB:  res_o.result = sum_i;
            OP_SLT:  res_o.result = {{(EX_WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: res_o.result = {{(EX_WIDTH-1){1'b0}}, lt_u};
            OP_BEQ:  res_o.taken  = eq;
            OP_BNE:  res_o.taken  = ~eq;
            OP_BLT:  res_o.taken  = lt_s;
            OP_BGE:  res_o.taken  = ~lt_s;
            OP_BLTU: res_o.taken  = lt_u;
            OP_BGEU: res_o.taken  = ~lt_u;
            default: res_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage: registered execute-result stage with valid/ready on both sides.
//   clk_i, rst_ni                      clock, async active-low reset
//   valid_i / ready_o                  upstream handshake
//   op_i, sum_i, cout_i, ovf_i, rd_i   decoded op, adder outputs, destination
//   valid_o / ready_i                  downstream handshake
//   result_o, taken_o, rd_o, illegal_o registered head entry
// Build option EX_SKID_EN: two-entry skid buffer with a registered ready_o.
// Without it a single output register is used and ready_o depends
// combinationally on ready_i.
// WIDTH must equal ex_pkg::EX_WIDTH.
//
// Buffer states (EX_SKID_EN only):
//   state     | meaning
//   BUF_EMPTY | nothing held, valid_o = 0, ready_o = 1
//   BUF_ONE   | head valid, skid empty, ready_o = 1
//   BUF_TWO   | head and skid valid, ready_o = 0, valid_i ignored
module ex_result_stage
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH = EX_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    input  logic             ovf_i,
    input  logic [4:0]       rd_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             taken_o,
    output logic [4:0]       rd_o,
    output logic             illegal_o
);

    ex_res_t comp_res;
    ex_res_t new_entry;
    ex_res_t head_q;
    logic    accept;
    logic    drain;

    ex_res_compute u_compute (
        .op_i   (op_i),
        .sum_i  (sum_i),
        .cout_i (cout_i),
        .ovf_i  (ovf_i),
        .res_o  (comp_res)
    );

    always_comb begin
        new_entry    = comp_res;
        new_entry.rd = rd_i;
    end

    assign accept = valid_i & ready_o;
    assign drain  = valid_o & ready_i;

`ifdef EX_SKID_EN

    ex_buf_state_e state_q;
    ex_buf_state_e state_d;
    ex_res_t       skid_q;
    logic          ready_q;
    logic          load_head_new;
    logic          load_head_skid;
    logic          load_skid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    state_d       = BUF_ONE;
                    load_head_new = 1'b1;
                end
            end
            BUF_ONE: begin
                if (accept && drain) begin
                    load_head_new = 1'b1;
                end else if (accept) begin
                    state_d   = BUF_TWO;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (drain) begin
                    state_d        = BUF_ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // ready is precomputed from the next state so it leaves a flop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q <= 1'b0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            ready_q <= (state_d != BUF_TWO);
            if (load_head_new) begin
                head_q <= new_entry;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_entry;
            end
        end
    end

    assign ready_o = ready_q;
    assign valid_o = (state_q != BUF_EMPTY);

`else

    logic valid_q;
    logic init_q;

    // init_q holds ready_o low until the first edge after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q  <= 1'b0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            init_q <= 1'b1;
            if (accept) begin
                valid_q <= 1'b1;
                head_q  <= new_entry;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign ready_o = init_q & (~valid_q | ready_i);
    assign valid_o = valid_q;

`endif

    assign result_o  = head_q.result;
    assign taken_o   = head_q.taken;
    assign rd_o      = head_q.rd;
    assign illegal_o = head_q.illegal;

endmodule

// File: tb/tb_ex_result_stage.sv
module tb_ex_result_stage;
    import ex_pkg::*;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    logic [3:0]   op_i;
    logic [W-1:0] sum_i;
    logic         cout_i;
    logic         ovf_i;
    logic [4:0]   rd_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] result_o;
    logic         taken_o;
    logic [4:0]   rd_o;
    logic         illegal_o;

    always #5 clk_i = ~clk_i;

    ex_result_stage #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .sum_i     (sum_i),
        .cout_i    (cout_i),
        .ovf_i     (ovf_i),
        .rd_i      (rd_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .taken_o   (taken_o),
        .rd_o      (rd_o),
        .illegal_o (illegal_o)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         tk;
        logic [4:0]   rd;
        logic         ill;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_fail = 0;

    // operation currently offered upstream; held until accepted
    logic         off_v = 1'b0;
    logic [3:0]   off_op;
    logic [W-1:0] off_a;
    logic [W-1:0] off_b;
    logic [4:0]   off_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // architectural meaning of each op on the original operands a, b
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [4:0] rd);
        exp_t e;
        e.res = '0;
        e.tk  = 1'b0;
        e.rd  = rd;
        e.ill = 1'b0;
        case (op)
            4'd0: e.res = a + b;
            4'd1: e.res = a - b;
            4'd2: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd3: e.res = (a < b) ? 1 : 0;
            4'd4: e.tk  = (a == b);
            4'd5: e.tk  = (a != b);
            4'd6: e.tk  = ($signed(a) < $signed(b));
            4'd7: e.tk  = ($signed(a) >= $signed(b));
            4'd8: e.tk  = (a < b);
            4'd9: e.tk  = (a >= b);
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // upstream adder: a + b for ADD, a + ~b + 1 for everything else
    task automatic drive_adder(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] t;
        if (op == 4'd0) begin
            t     = {1'b0, a} + {1'b0, b};
            ovf_i = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        end else begin
            t     = {1'b0, a} + {1'b0, ~b} + 1;
            ovf_i = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
        end
        sum_i  = t[W-1:0];
        cout_i = t[W];
    endtask

    task automatic offer(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd);
        off_v  = 1'b1;
        off_op = op;
        off_a  = a;
        off_b  = b;
        off_rd = rd;
    endtask

    task automatic check_outputs();
        chk("valid_o", valid_o, q.size() > 0);
        if (q.size() > 0) begin
            chk("result_o", result_o, q[0].res);
            chk("taken_o", taken_o, q[0].tk);
            chk("rd_o", rd_o, q[0].rd);
            chk("illegal_o", illegal_o, q[0].ill);
        end
        if (q.size() == 0)
            chk("ready_empty", ready_o, 1);
        else if (q.size() >= 2)
            chk("ready_full", ready_o, 0);
        else if (ready_i)
            chk("ready_one_drain", ready_o, 1);
    endtask

    // called at a falling edge; runs one full clock and checks at the next falling edge
    task automatic cycle(input logic rdy);
        logic acc;
        logic drn;
        valid_i = off_v;
        op_i    = off_op;
        rd_i    = off_rd;
        drive_adder(off_op, off_a, off_b);
        ready_i = rdy;
        #1;
        acc = valid_i & ready_o;
        drn = valid_o & ready_i;
        @(posedge clk_i);
        if (drn && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            q.push_back(model(off_op, off_a, off_b, off_rd));
            off_v = 1'b0;
        end
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd);
        offer(op, a, b, rd);
        for (int k = 0; k < 8 && off_v; k++) cycle(1'b1);
        if (off_v) begin
            chk("accept_timeout", 1, 0);
            off_v = 1'b0;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 1;
            2: return '1;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic offer_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = pick();
        b = ($urandom_range(0, 4) == 0) ? a : pick();
        offer(4'($urandom_range(0, 15)), a, b, 5'($urandom_range(0, 31)));
    endtask

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        op_i    = '0;
        sum_i   = '0;
        cout_i  = 1'b0;
        ovf_i   = 1'b0;
        rd_i    = '0;
        off_op  = '0;
        off_a   = '0;
        off_b   = '0;
        off_rd  = '0;

        // reset state
        #12;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_ready_o", ready_o, 0);
        chk("rst_result_o", result_o, 0);
        chk("rst_taken_o", taken_o, 0);
        chk("rst_rd_o", rd_o, 0);
        chk("rst_illegal_o", illegal_o, 0);
        #11;
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        #1;
        chk("ready_before_first_edge", ready_o, 0);
        @(negedge clk_i);
        chk("ready_after_first_edge", ready_o, 1);
        chk("valid_after_release", valid_o, 0);

        // directed cases
        send(4'd0, 32'd5, 32'd7, 5'd3);
        chk("add_5_7", result_o, 32'd12);
        send(4'd2, 32'hFFFF_FFFF, 32'd1, 5'd4);
        chk("slt_m1_1", result_o, 32'd1);
        send(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd5);
        chk("sltu_max_1", result_o, 32'd0);
        send(4'd4, 32'd9, 32'd9, 5'd6);
        chk("beq_9_9", taken_o, 1);
        send(4'd6, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        chk("blt_ovf", taken_o, 0);
        send(4'd12, 32'd1, 32'd2, 5'd8);
        chk("illegal_12", illegal_o, 1);
        chk("illegal_12_result", result_o, 0);
        send(4'd1, 32'd3, 32'd10, 5'd9);
        chk("sub_3_10", result_o, 32'hFFFF_FFF9);
        send(4'd9, 32'd1, 32'hFFFF_FFFF, 5'd10);
        chk("bgeu_1_max", taken_o, 0);
        for (int k = 0; k < 2; k++) cycle(1'b1);

        // backpressure: A, B, C offered while downstream stalls, then drained
        begin
            int sent;
            sent = 0;
            for (int k = 0; k < 4; k++) begin
                if (!off_v && sent < 3) begin
                    offer(4'd0, 32'(100 + sent), 32'd0, 5'(20 + sent));
                    sent++;
                end
                cycle(1'b0);
            end
            for (int k = 0; k < 8; k++) begin
                if (!off_v && sent < 3) begin
                    offer(4'd0, 32'(100 + sent), 32'd0, 5'(20 + sent));
                    sent++;
                end
                cycle(1'b1);
            end
            chk("bp_all_offered", sent, 3);
            chk("bp_drained", valid_o, 0);
        end

        // randomized traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            if (!off_v && $urandom_range(0, 3) != 0) offer_random();
            cycle($urandom_range(0, 3) != 0);
        end

        // fill under backpressure, then reset mid-stream
        for (int k = 0; k < 3; k++) begin
            if (!off_v) offer_random();
            cycle(1'b0);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid_o", valid_o, 0);
        chk("midrst_ready_o", ready_o, 0);
        chk("midrst_result_o", result_o, 0);
        chk("midrst_taken_o", taken_o, 0);
        chk("midrst_illegal_o", illegal_o, 0);
        q.delete();
        off_v   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_ready_after", ready_o, 1);
        chk("midrst_no_stale", valid_o, 0);
        for (int k = 0; k < 3; k++) cycle(1'b1);

        for (int k = 0; k < 100; k++) begin
            if (!off_v && $urandom_range(0, 1) != 0) offer_random();
            cycle($urandom_range(0, 2) != 0);
        end
        off_v = 1'b0;
        for (int k = 0; k < 4; k++) cycle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
